adpcm_tx_framer: RTL and testbench
==================================

// Module: adpcm_tx_framer
// PURPOSE
//  Downstream of the encoder's code register file. Collects the 5-bit ADPCM codes I for
//  NUM_CHN channels into a ping-pong buffer and shifts them out as one serial TDM frame:
//  codes MSB first, rate-dependent width.
//  Generates the output bit clock and frame sync from the single system clock.
// PARAMETERS
//  NUM_CHN    8      channel slots per frame (power of 2, 2..8)
//  CLK_DIV    8      clk cycles per serial bit (even, >=4)
//  IDLE_CODE  5'h00  code sent for a slot not written since the last swap
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset      in   1  asynchronous, active-high reset
//  rate       in   2  00=16k(2b) 01=24k(3b) 10=32k(4b) 11=40k(5b); sampled at frame start
//  wr_en      in   1  write strobe, one clk cycle per code
//  wr_addr    in   3  channel slot; bits above log2(NUM_CHN) ignored
//  wr_data    in   5  ADPCM code; only the low nbits are transmitted
//  frame_strb in   1  one-cycle pulse: swap banks, start a frame
//  ser_data   out  1  serial ADPCM data
//  ser_clk    out  1  bit clock; data changes on its rise, sampled on its fall
//  ser_fs     out  1  high for the whole first bit period of a frame
//  busy       out  1  high while a frame is shifting
//  ovr_error  out  1  sticky: frame_strb arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE, wr_bank=0. All slot-valid flags cleared.
//   Both banks hold IDLE_CODE.
//  Buffer: 2 banks x NUM_CHN x 5b plus valid[bank][slot]. wr_en writes wr_data to
//   bank wr_bank, slot wr_addr, and sets that slot's valid flag. A later write to the same
//   slot overwrites it (last wins).
//  Swap on frame_strb: tx_bank<=wr_bank and wr_bank<=~wr_bank. The valid flags of the new
//   write bank are cleared. A wr_en in the same cycle as frame_strb writes the old
//   wr_bank, so that code IS in the frame now starting.
//  nbits = rate+2. The rate is latched at the swap and is fixed for the whole frame.
//   A rate change mid-frame has no effect until the next frame_strb.
//  FSM IDLE->SHIFT on frame_strb.
//   - The cycle after the strobe: busy=1, ser_fs=1, ser_clk=1, ser_data=MSB of slot 0.
//   - Each bit lasts CLK_DIV cycles. ser_clk is high for the first CLK_DIV/2 cycles and
//     low for the remaining CLK_DIV/2.
//   - Counters: div_cnt wraps CLK_DIV-1->0 and advances bit_cnt. bit_cnt wraps
//     nbits-1->0 and advances chn. chn wraps NUM_CHN-1 at frame end.
//   - ser_fs falls at the end of the first bit period.
//  Transmitted code per slot = valid ? stored code : IDLE_CODE. Bit order is bit nbits-1
//   down to bit 0.
//  Frame length = NUM_CHN*nbits*CLK_DIV clk cycles; at defaults with rate=11 that is
//   320 cycles.
//  SHIFT->IDLE after the last bit period. The next cycle: busy=0, ser_clk=0, ser_data=0.
//   A frame_strb in that same next cycle is legal and starts a frame with no error.
//  frame_strb while busy:
//   - ovr_error<=1 (sticky until reset).
//   - The current frame is aborted and a new frame starts with a swap.
//   - Frame timing always follows the strobe.
//  Async reset mid-frame: immediate return to reset values and the frame is lost.
//   No partial bits after reset deasserts.
// CONFIGURATION
//  ADPCM_TX_PARITY_EN defined:
//   - Each slot carries nbits code bits followed by 1 even-parity bit over the
//     transmitted code bits.
//   - Slot length nbits+1. Frame length NUM_CHN*(nbits+1)*CLK_DIV.
//   - IDLE_CODE slots carry parity too.
//  Not defined: no parity bit; slot length nbits; no parity logic is synthesized.
// TESTING
//  1 Reset: assert reset with the FSM in SHIFT -> all outputs 0 in the same cycle;
//    frame_strb after release -> all 8 slots send IDLE_CODE.
//  2 rate=10, write slot i=5'h10|i for i=0..7, frame_strb -> 32 bits 0000,0001,..,0111;
//    ser_fs high cycles 1..8; busy high 256 cycles.
//  3 rate=11, write slot3=5'h15 only, frame_strb -> slot3 bits 10101, other slots 00000,
//    40 bits. Change rate mid-frame -> frame stays 40 bits.
//  4 Ping-pong: while frame A shifts, write codes B and also pulse wr_en with frame_strb
//    on the same cycle -> frame A unaffected; next frame carries B and the same-cycle
//    write.
//  5 frame_strb at cycle 100 of a 256-cycle frame -> ovr_error=1 and held; new frame
//    starts the next cycle with ser_fs=1.
//  6 ADPCM_TX_PARITY_EN, rate=00, slot0=2'b11, slot1=2'b01 -> slot bits 110, 011;
//    frame 24 bits.

Source files
------------

// File: rtl/adpcm_tx_framer_if.sv
// Parallel code-write / frame-strobe side and serial TDM output side of adpcm_tx_framer.
// master = code source and serial sink, slave = the framer.
interface adpcm_tx_framer_if;
    logic [1:0] rate;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       frame_strb;
    logic       ser_data;
    logic       ser_clk;
    logic       ser_fs;
    logic       busy;
    logic       ovr_error;

    modport master (
        output rate, wr_en, wr_addr, wr_data, frame_strb,
        input  ser_data, ser_clk, ser_fs, busy, ovr_error
    );

    modport slave (
        input  rate, wr_en, wr_addr, wr_data, frame_strb,
        output ser_data, ser_clk, ser_fs, busy, ovr_error
    );
endinterface

// File: rtl/adpcm_tx_framer.sv
// Ping-pong code buffer shifted out as a serial TDM frame; first bit appears the cycle after frame_strb.
// No backpressure: a strobe while busy aborts the frame and sets ovr_error; ADPCM_TX_PARITY_EN adds a parity bit per slot.
module adpcm_tx_framer #(
    parameter int         NUM_CHN   = 8,
    parameter int         CLK_DIV   = 8,
    parameter logic [4:0] IDLE_CODE = 5'h00
) (
    input  logic               clk,
    input  logic               reset,
    adpcm_tx_framer_if.slave   bus
);
    localparam int AW = $clog2(NUM_CHN);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_SHIFT  = 1'b1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [AW-1:0] LAST_CHN = AW'(NUM_CHN - 1);

    logic [4:0]         r_mem [2][NUM_CHN];
    logic [NUM_CHN-1:0] r_vld [2];
    logic               r_wr_bank;
    logic               r_tx_bank;
    logic [1:0]         r_rate;
    logic [0:0]         r_state;
    logic [DW-1:0]      r_div_cnt;
    logic [2:0]         r_bit_cnt;
    logic [AW-1:0]      r_chn;
    logic               r_ovr;

    logic [AW-1:0] w_addr;
    logic [2:0]    w_nbits;
    logic [2:0]    w_slot_last;
    logic [2:0]    w_bit_idx;
    logic [4:0]    w_code;
    logic          w_busy;
    logic          w_data_bit;

    assign w_addr    = bus.wr_addr[AW-1:0];
    assign w_nbits   = {1'b0, r_rate} + 3'd2;
    assign w_bit_idx = w_nbits - 3'd1 - r_bit_cnt;
    assign w_code    = r_vld[r_tx_bank][r_chn] ? r_mem[r_tx_bank][r_chn] : IDLE_CODE;
    assign w_busy    = (r_state == S_SHIFT);

`ifdef ADPCM_TX_PARITY_EN
    logic [4:0] w_mask;

    always_comb begin
        w_mask = 5'b11111;
        case (r_rate)
            2'b00:   w_mask = 5'b00011;
            2'b01:   w_mask = 5'b00111;
            2'b10:   w_mask = 5'b01111;
            default: w_mask = 5'b11111;
        endcase
    end

    // Extra bit position nbits carries even parity over the transmitted code bits only.
    assign w_slot_last = w_nbits;
    assign w_data_bit  = (r_bit_cnt == w_nbits) ? ^(w_code & w_mask) : w_code[w_bit_idx];
`else
    assign w_slot_last = w_nbits - 3'd1;
    assign w_data_bit  = w_code[w_bit_idx];
`endif

    assign bus.busy      = w_busy;
    assign bus.ser_clk   = w_busy && (r_div_cnt < DIV_HALF);
    assign bus.ser_fs    = w_busy && (r_chn == '0) && (r_bit_cnt == 3'd0);
    assign bus.ser_data  = w_busy && w_data_bit;
    assign bus.ovr_error = r_ovr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_CHN; c++) begin
                    r_mem[b][c] <= IDLE_CODE;
                end
                r_vld[b] <= '0;
            end
            r_wr_bank <= 1'b0;
            r_tx_bank <= 1'b0;
            r_rate    <= 2'b00;
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_chn     <= '0;
            r_ovr     <= 1'b0;
        end else begin
            // A write coinciding with the strobe lands in the bank that is about to transmit.
            if (bus.wr_en) begin
                r_mem[r_wr_bank][w_addr] <= bus.wr_data;
                r_vld[r_wr_bank][w_addr] <= 1'b1;
            end
            if (bus.frame_strb) begin
                r_vld[~r_wr_bank] <= '0;
                r_tx_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_rate    <= bus.rate;
                r_state   <= S_SHIFT;
                r_div_cnt <= '0;
                r_bit_cnt <= 3'd0;
                r_chn     <= '0;
                if (w_busy) r_ovr <= 1'b1;
            end else if (w_busy) begin
                if (r_div_cnt != DIV_LAST) begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end else begin
                    r_div_cnt <= '0;
                    if (r_bit_cnt != w_slot_last) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_bit_cnt <= 3'd0;
                        if (r_chn != LAST_CHN) begin
                            r_chn <= r_chn + 1'b1;
                        end else begin
                            r_chn   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adpcm_tx_framer.sv
// Randomised bench for adpcm_tx_framer: a bank/bit-list model predicts every output cycle of each frame.
module tb_adpcm_tx_framer;
    localparam int         NUM_CHN   = 8;
    localparam int         CLK_DIV   = 8;
    localparam logic [4:0] IDLE_CODE = 5'h00;
`ifdef ADPCM_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adpcm_tx_framer_if bus ();

    adpcm_tx_framer #(.NUM_CHN(NUM_CHN), .CLK_DIV(CLK_DIV), .IDLE_CODE(IDLE_CODE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] m_mem [2][NUM_CHN];
    bit         m_vld [2][NUM_CHN];
    bit         m_wb;
    bit         exp_bits [$];
    bit         exp_ovr;
    logic [7:0] wr_q [$];

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NUM_CHN; c++) begin
                m_mem[b][c] = IDLE_CODE;
                m_vld[b][c] = 1'b0;
            end
        m_wb    = 1'b0;
        exp_ovr = 1'b0;
        exp_bits.delete();
    endfunction

    function automatic void model_write(input int a, input logic [4:0] d);
        m_mem[m_wb][a % NUM_CHN] = d;
        m_vld[m_wb][a % NUM_CHN] = 1'b1;
    endfunction

    // Swap banks and expand the transmit bank into the list of serial bits of the frame.
    function automatic void model_strobe(input int rt);
        int n;
        bit tx;
        bit p;
        logic [4:0] code;
        n  = rt + 2;
        tx = m_wb;
        m_wb = !m_wb;
        for (int c = 0; c < NUM_CHN; c++) m_vld[m_wb][c] = 1'b0;
        exp_bits.delete();
        for (int ch = 0; ch < NUM_CHN; ch++) begin
            code = m_vld[tx][ch] ? m_mem[tx][ch] : IDLE_CODE;
            p = 1'b0;
            for (int b = n - 1; b >= 0; b--) begin
                exp_bits.push_back(code[b]);
                p = p ^ code[b];
            end
            if (PAR) exp_bits.push_back(p);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 3'd0;
        bus.wr_data    = 5'd0;
        bus.frame_strb = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [4:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        model_write(a, d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic apply_reset();
        logic [4:0] got;
        reset = 1'b1;
        idle_inputs();
        #2;
        got = {bus.busy, bus.ser_fs, bus.ser_clk, bus.ser_data, bus.ovr_error};
        n_checks++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs {busy,fs,clk,data,ovr} got %b expected 00000", got);
        end
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    // Strobe a frame and check every cycle of it; returns early at cycle abort_k leaving the caller to re-strobe.
    task automatic run_frame(input logic [1:0] rt, input bit same_wr, input logic [7:0] same_w,
                             input int abort_k, input int rchg_k, output int busy_cyc);
        int flen;
        logic [4:0] got, exp;
        logic [7:0] w;
        bus.rate = rt;
        bus.frame_strb = 1'b1;
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = same_w[7:5];
            bus.wr_data = same_w[4:0];
            model_write(int'(same_w[7:5]), same_w[4:0]);
        end
        model_strobe(int'(rt));
        tick();
        bus.frame_strb = 1'b0;
        bus.wr_en = 1'b0;
        flen = exp_bits.size() * CLK_DIV;
        busy_cyc = 0;
        for (int k = 0; k < flen; k++) begin
            exp = {1'b1, k < CLK_DIV, (k % CLK_DIV) < (CLK_DIV / 2), exp_bits[k / CLK_DIV], exp_ovr};
            got = {bus.busy, bus.ser_fs, bus.ser_clk, bus.ser_data, bus.ovr_error};
            if (bus.busy === 1'b1) busy_cyc++;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL frame_cycle k=%0d {busy,fs,clk,data,ovr} got %b expected %b", k, got, exp);
            end
            if (k == abort_k) return;
            bus.wr_en = 1'b0;
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                bus.wr_en   = 1'b1;
                bus.wr_addr = w[7:5];
                bus.wr_data = w[4:0];
                model_write(int'(w[7:5]), w[4:0]);
            end
            if (k == rchg_k) bus.rate = rt ^ 2'($urandom_range(1, 3));
            tick();
        end
        bus.wr_en = 1'b0;
        got = {bus.busy, bus.ser_fs, bus.ser_clk, bus.ser_data, bus.ovr_error};
        n_checks++;
        if (got !== {4'b0000, exp_ovr}) begin
            n_fail++;
            $display("FAIL idle_after_frame {busy,fs,clk,data,ovr} got %b expected %b", got, {4'b0000, exp_ovr});
        end
    endtask

    task automatic check_busy(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s busy cycles got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        int bc;
        logic [4:0] got;
        apply_reset();
        do_write(2, 5'h1b);
        run_frame(2'b11, 1'b0, 8'h00, 40, -1, bc);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            got = {bus.busy, bus.ser_fs, bus.ser_clk, bus.ser_data, bus.ovr_error};
            n_checks++;
            if (got !== 5'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet i=%0d got %b expected 00000", i, got);
            end
            tick();
        end
        run_frame(2'b11, 1'b0, 8'h00, -1, -1, bc);
        check_busy("reset_idle_frame", bc, 320);
    endtask

    task automatic test_rate32();
        int bc;
        for (int i = 0; i < NUM_CHN; i++) do_write(i, 5'h10 | 5'(i));
        run_frame(2'b10, 1'b0, 8'h00, -1, -1, bc);
        check_busy("rate32", bc, 256);
    endtask

    task automatic test_rate40_midchange();
        int bc;
        do_write(3, 5'h15);
        run_frame(2'b11, 1'b0, 8'h00, -1, 100, bc);
        check_busy("rate40_midchange", bc, 320);
    endtask

    task automatic test_ping_pong();
        int bc;
        logic [1:0] ra, rb;
        ra = 2'($urandom);
        rb = 2'($urandom);
        for (int i = 0; i < NUM_CHN; i++) do_write(i, 5'($urandom));
        for (int i = 0; i < 10; i++) wr_q.push_back(8'($urandom));
        run_frame(ra, 1'b0, 8'h00, -1, -1, bc);
        check_busy("ping_pong_A", bc, NUM_CHN * (int'(ra) + 2 + int'(PAR)) * CLK_DIV);
        run_frame(rb, 1'b1, 8'($urandom), -1, -1, bc);
        check_busy("ping_pong_B", bc, NUM_CHN * (int'(rb) + 2 + int'(PAR)) * CLK_DIV);
    endtask

    task automatic test_overrun();
        int bc;
        logic [1:0] rn;
        for (int i = 0; i < NUM_CHN; i++) do_write(i, 5'($urandom));
        run_frame(2'b10, 1'b0, 8'h00, 100, -1, bc);
        exp_ovr = 1'b1;
        rn = 2'($urandom);
        run_frame(rn, 1'b0, 8'h00, -1, -1, bc);
        check_busy("overrun_new_frame", bc, NUM_CHN * (int'(rn) + 2 + int'(PAR)) * CLK_DIV);
        run_frame(2'b00, 1'b0, 8'h00, -1, -1, bc);
    endtask

    task automatic test_parity();
        int bc;
        apply_reset();
        do_write(0, 5'b10111);
        do_write(1, 5'b01001);
        run_frame(2'b00, 1'b0, 8'h00, -1, -1, bc);
        check_busy("parity_rate16", bc, PAR ? 192 : 128);
    endtask

    task automatic test_random();
        int bc;
        logic [1:0] r;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 6; i++) do_write(int'($urandom_range(0, 7)), 5'($urandom));
            r = 2'($urandom);
            run_frame(r, 1'b0, 8'h00, -1, -1, bc);
            check_busy("random_frame", bc, NUM_CHN * (int'(r) + 2 + int'(PAR)) * CLK_DIV);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.rate = 2'b00;
        idle_inputs();
        test_reset();
        test_rate32();
        test_rate40_midchange();
        test_ping_pong();
        test_overrun();
        test_parity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
